sd_xfer_scheduler: RTL and testbench
====================================

# sd_xfer_scheduler

Sequences block transfers through the SD-card mode controller on behalf of the USB-side command decoder. For each request it loads the 6-byte address/size header into the receive FIFO, strobes the controller's address-load path, then issues the read or write strobe. It supervises completion with a watchdog timeout and bounded retry of reads, and returns a single status response per request. It sits between the USB command decoder and the SD mode controller and is the only driver of the controller's `sd_addr_ready`, `sd_read` and `sd_write` inputs.

## Interface
- `MAX_RETRY`, default 2: extra attempts allowed for a failed read; writes are never retried.
- `TO_W`, default 20: watchdog width; timeout fires when the counter reaches all-ones (2^TO_W − 1 cycles).
- `SETTLE`, default 32: cycles to wait after `sd_addr_ready` before issuing the read/write strobe.
- `clk` in 1: single clock; everything is posedge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: request present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: SD block address.
- `cmd_size` in 16: transfer size in bytes.
- `fifo_full` in 1: receive FIFO full.
- `hdr_push` out 1: write strobe into the receive FIFO.
- `hdr_byte` out 8: header byte.
- `sd_addr_ready` out 1: one-cycle pulse to the controller.
- `sd_read` out 1: one-cycle pulse to the controller.
- `sd_write` out 1: one-cycle pulse to the controller.
- `sd_done` in 1: controller completion pulse.
- `sd_err` in 1: controller error pulse.
- `busy` out 1: high in any state other than IDLE.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_code` out 2: response code. 00 = ok, 01 = sd_err after retries exhausted, 10 = timeout, 11 = size zero. Held until the next response.

## Operation
- States: IDLE, HDR, ADDR_REQ, SETTLE_W, CMD, XFER, RETRY, RESP.
- **IDLE**
  - On `cmd_valid`, latch `cmd_write`, `cmd_addr` and `cmd_size`, and clear the retry count.
  - If `cmd_size` is 0, go to RESP with code 11. Otherwise go to HDR.
- **HDR**
  - Byte index `i` runs 0..5. Sequence: `addr[31:24]`, `addr[23:16]`, `addr[15:8]`, `addr[7:0]`, `size[15:8]`, `size[7:0]`.
  - `hdr_push = ~fifo_full`. `i` increments only on a push.
  - After pushing `i = 5`, go to ADDR_REQ.
- **ADDR_REQ**: `sd_addr_ready` = 1 for exactly one cycle; clear the wait counter; go to SETTLE_W.
- **SETTLE_W**: count up; when count = `SETTLE` − 1, go to CMD.
- **CMD**: pulse `sd_write` if the latched request is a write, else `sd_read`; clear the watchdog; go to XFER.
- **XFER**
  - Watchdog increments every cycle.
  - `sd_err` has priority over `sd_done` when both are high.
  - On `sd_err`: for a read with retry count < `MAX_RETRY`, go to RETRY; otherwise go to RESP with code 01.
  - On `sd_done` (no error): go to RESP with code 00.
  - On watchdog all-ones: go to RESP with code 10. Timeouts are not retried.
- **RETRY**: increment the retry count; reset `i` to 0; go to HDR to re-push the header.
- **RESP**: `resp_valid` = 1 for one cycle with `resp_code`; go to IDLE.
- `sd_done` and `sd_err` arriving outside XFER are ignored.

## Timing
- Reset values: state IDLE, `cmd_ready` 1, `busy` 0, and all of the following 0: `hdr_push`, `hdr_byte`, `sd_addr_ready`, `sd_read`, `sd_write`, `resp_valid`, `resp_code`, `i`, retry count, watchdog.
- Reset asserted mid-transfer aborts immediately. No response is issued and no strobes are generated after release.
- All outputs are registered or decoded from state plus counters. `hdr_byte` is valid whenever `hdr_push` is high.
- Accept happens on the edge where `cmd_valid & cmd_ready` are both high.
- With `fifo_full` never asserted:
  - `hdr_push` is high for the 6 cycles after accept.
  - `sd_addr_ready` fires in cycle 7 after accept.
  - The read/write strobe fires in cycle 8 + `SETTLE`.
- `fifo_full` stalls HDR with no byte lost or duplicated.
- A size-zero request produces `resp_valid` in the cycle after accept with no SD strobes.
- Widths:
  - Watchdog is `TO_W` bits and does not wrap; it compares equal to all-ones.
  - Retry count is `$clog2(MAX_RETRY+1)` bits.
- `cmd_ready` is 0 in RESP. A new request can be accepted at the earliest one cycle after `resp_valid`.

## Test plan
- **Read ok**: read, addr 0x00001200, size 0x0200; `sd_done` 5 cycles after `sd_read` -> header bytes 00 00 12 00 02 00, one `sd_addr_ready`, one `sd_read`, `resp_code` 00.
- **Backpressure**: `fifo_full` high on the 2nd and 4th push cycles -> exactly 6 pushes, byte order unchanged, `sd_addr_ready` delayed by 2 cycles.
- **Read retry**: `sd_err` on attempts 1 and 2, `sd_done` on attempt 3 with `MAX_RETRY`=2 -> 18 header pushes, 3 `sd_read` pulses, code 00. With an `sd_err` on the 3rd attempt instead -> code 01.
- **Write error**: write request, `sd_err` once -> no retry, a single `sd_write` pulse, code 01. Same request with `sd_done` and `sd_err` in the same cycle -> code 01.
- **Timeout and size zero**: `TO_W`=6, no response -> code 10 after 63 XFER cycles. A size-0 request -> code 11, no strobes.
- **Reset mid-XFER**: assert `n_rst` low, release, inject `sd_done` -> no `resp_valid`, `cmd_ready` 1, next request completes normally.

Source files
------------

// File: rtl/sd_xfer_scheduler.sv
// Block-transfer sequencer for the SD mode controller.
// Pushes the address/size header, strobes the controller and supervises completion.
module sd_xfer_scheduler #(
  parameter int MAX_RETRY = 2,
  parameter int TO_W      = 20,
  parameter int SETTLE    = 32
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_size,
  input  logic        fifo_full,
  output logic        hdr_push,
  output logic [7:0]  hdr_byte,
  output logic        sd_addr_ready,
  output logic        sd_read,
  output logic        sd_write,
  input  logic        sd_done,
  input  logic        sd_err,
  output logic        busy,
  output logic        resp_valid,
  output logic [1:0]  resp_code
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);
  localparam logic [TO_W-1:0] ONES = '1;
  localparam logic [TO_W-1:0] TLAST = ONES - TO_W'(1);

  typedef enum logic [2:0] {
    IDLE, HDR, ADDR_REQ, SETTLE_W, CMD, XFER, RETRY, RESP
  } state_t;

  state_t state, state_nx;

  logic            wr_q;
  logic [31:0]     addr_q;
  logic [15:0]     size_q;
  logic [2:0]      idx;
  logic [RW-1:0]   rcnt;
  logic [SW-1:0]   cnt;
  logic [TO_W-1:0] wd;

  logic accept, push, can_retry, to_hit;

  assign accept    = (state == IDLE) & cmd_valid;
  assign push      = (state == HDR) & ~fifo_full;
  assign can_retry = ~wr_q & (rcnt < RMAX);
  // Fires on the cycle the watchdog steps onto all-ones.
  assign to_hit    = (wd == TLAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cmd_valid)
                  state_nx = (cmd_size == '0) ? RESP : HDR;
      HDR:      if (push && idx == 3'd5) state_nx = ADDR_REQ;
      ADDR_REQ: state_nx = SETTLE_W;
      SETTLE_W: if (cnt == SLAST) state_nx = CMD;
      CMD:      state_nx = XFER;
      XFER:     if (sd_err)
                  state_nx = can_retry ? RETRY : RESP;
                else if (sd_done || to_hit)
                  state_nx = RESP;
      RETRY:    state_nx = HDR;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      idx       <= '0;
      rcnt      <= '0;
      cnt       <= '0;
      wd        <= '0;
      resp_code <= 2'b00;
    end else begin
      if (accept) begin
        wr_q   <= cmd_write;
        addr_q <= cmd_addr;
        size_q <= cmd_size;
        rcnt   <= '0;
        idx    <= '0;
        if (cmd_size == '0) resp_code <= 2'b11;
      end
      if (push) idx <= idx + 3'd1;
      if (state == ADDR_REQ) cnt <= '0;
      if (state == SETTLE_W) cnt <= cnt + SW'(1);
      if (state == CMD) wd <= '0;
      if (state == XFER) begin
        if (wd != ONES) wd <= wd + TO_W'(1);
        if (sd_err) begin
          if (!can_retry) resp_code <= 2'b01;
        end else if (sd_done) begin
          resp_code <= 2'b00;
        end else if (to_hit) begin
          resp_code <= 2'b10;
        end
      end
      if (state == RETRY) begin
        rcnt <= rcnt + RW'(1);
        idx  <= '0;
      end
    end
  end

  always_comb begin
    cmd_ready     = (state == IDLE);
    busy          = (state != IDLE);
    hdr_push      = push;
    sd_addr_ready = (state == ADDR_REQ);
    sd_read       = (state == CMD) & ~wr_q;
    sd_write      = (state == CMD) & wr_q;
    resp_valid    = (state == RESP);
    hdr_byte      = '0;
    if (state == HDR) begin
      unique case (idx)
        3'd0:    hdr_byte = addr_q[31:24];
        3'd1:    hdr_byte = addr_q[23:16];
        3'd2:    hdr_byte = addr_q[15:8];
        3'd3:    hdr_byte = addr_q[7:0];
        3'd4:    hdr_byte = size_q[15:8];
        3'd5:    hdr_byte = size_q[7:0];
        default: hdr_byte = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_xfer_scheduler.sv
// Scoreboard bench for sd_xfer_scheduler.
// Header bytes and response codes are queued at request time and popped on output.
module tb_sd_xfer_scheduler;

  localparam int SET = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_size;
  logic        fifo_full, hdr_push;
  logic [7:0]  hdr_byte;
  logic        sd_addr_ready, sd_read, sd_write;
  logic        sd_done, sd_err, busy, resp_valid;
  logic [1:0]  resp_code;

  sd_xfer_scheduler #(.MAX_RETRY(2), .TO_W(6), .SETTLE(SET)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .fifo_full(fifo_full),
    .hdr_push(hdr_push), .hdr_byte(hdr_byte),
    .sd_addr_ready(sd_addr_ready), .sd_read(sd_read),
    .sd_write(sd_write), .sd_done(sd_done),
    .sd_err(sd_err), .busy(busy),
    .resp_valid(resp_valid), .resp_code(resp_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_ar = 0, n_rd = 0, n_wr = 0, n_push = 0, n_resp = 0;
  int t_ar = 0, t_rd = 0, t_resp = 0;
  int b_ar, b_rd, b_wr, b_push, b_resp;
  int k_acc;
  int resp_dly = 5;
  logic [7:0] exp_hdr[$];
  logic [1:0] exp_resp[$];
  int react[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hdr_push) begin
      n_push++;
      if (exp_hdr.size() == 0) chk("hdr_extra", 1, 0);
      else chk("hdr_byte", {24'h0, hdr_byte}, {24'h0, exp_hdr.pop_front()});
    end
    if (resp_valid) begin
      n_resp++;
      t_resp = cyc;
      if (exp_resp.size() == 0) chk("resp_extra", 1, 0);
      else chk("resp_code", {30'h0, resp_code}, {30'h0, exp_resp.pop_front()});
    end
    if (sd_addr_ready) begin n_ar++; t_ar = cyc; end
    if (sd_read) begin n_rd++; t_rd = cyc; end
    if (sd_write) begin n_wr++; t_rd = cyc; end
  end

  // Controller model: answers each strobe after resp_dly cycles.
  // 0 = done, 1 = err, 2 = both, 3 = silent.
  initial begin
    int r;
    sd_done = 1'b0;
    sd_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (n_rst && (sd_read || sd_write)) begin
        r = (react.size() > 0) ? react.pop_front() : 3;
        repeat (resp_dly) @(posedge clk);
        #1;
        sd_done = (r == 0 || r == 2);
        sd_err  = (r == 1 || r == 2);
        @(posedge clk);
        #1;
        sd_done = 1'b0;
        sd_err  = 1'b0;
      end
    end
  end

  task automatic snap();
    b_ar = n_ar; b_rd = n_rd; b_wr = n_wr;
    b_push = n_push; b_resp = n_resp;
  endtask

  task automatic start_req(input logic wr, input logic [31:0] a,
                           input logic [15:0] s, input int tries,
                           input logic [1:0] code);
    for (int t = 0; t < tries; t++) begin
      exp_hdr.push_back(a[31:24]);
      exp_hdr.push_back(a[23:16]);
      exp_hdr.push_back(a[15:8]);
      exp_hdr.push_back(a[7:0]);
      exp_hdr.push_back(s[15:8]);
      exp_hdr.push_back(s[7:0]);
    end
    exp_resp.push_back(code);
    snap();
    @(posedge clk);
    #1;
    chk("cmd_ready_pre", {31'h0, cmd_ready}, 1);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    k_acc     = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int k = 0;
    while (n_resp == b_resp && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("resp_seen", {31'h0, n_resp != b_resp}, 1);
    @(posedge clk);
  endtask

  initial begin
    n_rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_size = '0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, cmd_ready}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_push", {31'h0, hdr_push}, 0);
    chk("rst_byte", {24'h0, hdr_byte}, 0);
    chk("rst_strobes", {29'h0, sd_addr_ready, sd_read, sd_write}, 0);
    chk("rst_resp", {29'h0, resp_valid, resp_code}, 0);

    // read ok
    react.push_back(0);
    start_req(1'b0, 32'h0000_1200, 16'h0200, 1, 2'b00);
    wait_resp();
    chk("ok_ar_t", t_ar - k_acc, 6);
    chk("ok_rd_t", t_rd - k_acc, 7 + SET);
    chk("ok_resp_t", t_resp - t_rd, 6);
    chk("ok_ar_n", n_ar - b_ar, 1);
    chk("ok_rd_n", n_rd - b_rd, 1);
    chk("ok_wr_n", n_wr - b_wr, 0);
    chk("ok_push_n", n_push - b_push, 6);

    // backpressure on the 2nd and 4th HDR cycles
    react.push_back(0);
    start_req(1'b0, 32'hA5C3_0F01, 16'h8010, 1, 2'b00);
    @(posedge clk); #1 fifo_full = 1'b1;
    @(posedge clk); #1 fifo_full = 1'b0;
    @(posedge clk); #1 fifo_full = 1'b1;
    @(posedge clk); #1 fifo_full = 1'b0;
    wait_resp();
    chk("bp_ar_t", t_ar - k_acc, 8);
    chk("bp_push_n", n_push - b_push, 6);

    // read retry then success
    react.push_back(1); react.push_back(1); react.push_back(0);
    start_req(1'b0, 32'h1234_5678, 16'h0040, 3, 2'b00);
    wait_resp();
    chk("rt_push_n", n_push - b_push, 18);
    chk("rt_rd_n", n_rd - b_rd, 3);
    chk("rt_ar_n", n_ar - b_ar, 3);

    // retries exhausted
    react.push_back(1); react.push_back(1); react.push_back(1);
    start_req(1'b0, 32'h0BAD_F00D, 16'h0001, 3, 2'b01);
    wait_resp();
    chk("rx_rd_n", n_rd - b_rd, 3);

    // write error, never retried
    react.push_back(1);
    start_req(1'b1, 32'hFFEE_DDCC, 16'h0200, 1, 2'b01);
    wait_resp();
    chk("we_wr_n", n_wr - b_wr, 1);
    chk("we_rd_n", n_rd - b_rd, 0);
    chk("we_push_n", n_push - b_push, 6);

    // done and err together: err wins
    react.push_back(2);
    start_req(1'b1, 32'hFFEE_DDCC, 16'h0200, 1, 2'b01);
    wait_resp();
    chk("wb_wr_n", n_wr - b_wr, 1);

    // watchdog timeout
    react.push_back(3);
    start_req(1'b0, 32'h0000_0001, 16'h0200, 1, 2'b10);
    wait_resp();
    chk("to_resp_t", t_resp - t_rd, 64);
    chk("to_rd_n", n_rd - b_rd, 1);

    // size zero
    start_req(1'b0, 32'h0000_4000, 16'h0000, 0, 2'b11);
    wait_resp();
    chk("sz_resp_t", t_resp - k_acc, 0);
    chk("sz_strobes", (n_ar - b_ar) + (n_rd - b_rd) + (n_wr - b_wr), 0);
    chk("sz_push_n", n_push - b_push, 0);

    // reset in XFER; the late sd_done must be ignored
    resp_dly = 12;
    react.push_back(0);
    start_req(1'b0, 32'h7777_0000, 16'h0100, 1, 2'b00);
    begin
      int k = 0;
      while (n_rd == b_rd && k < 200) begin
        @(posedge clk);
        k++;
      end
    end
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    exp_hdr.delete();
    exp_resp.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("rs_resp_n", n_resp - b_resp, 0);
    chk("rs_ready", {31'h0, cmd_ready}, 1);
    chk("rs_busy", {31'h0, busy}, 0);
    resp_dly = 5;
    react.push_back(0);
    start_req(1'b0, 32'h0102_0304, 16'h0506, 1, 2'b00);
    wait_resp();
    chk("rs_next_rd_n", n_rd - b_rd, 1);

    chk("hdr_left", exp_hdr.size(), 0);
    chk("resp_left", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
